// File: rtl/call_stack_ctrl.sv
`timescale 1ns/1ps
// call_stack_ctrl: return-address stack sequencer sitting in front of the
// sync_lifo call stack. Decode-side requests (CALL/RET/TAIL) become LIFO
// push/pop/replace operations, and popped addresses go back to fetch.
// Optional build macro CALL_STACK_WATERMARK_EN adds the max_depth output.
module call_stack_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int LIFO_DEPTH = 32,
  parameter int CNT_WIDTH  = $clog2(LIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_type,
  input  logic [ADDR_WIDTH-1:0] req_pc,
  input  logic                  flush,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [ADDR_WIDTH-1:0] resp_pc,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] lifo_wdata,
  input  logic [ADDR_WIDTH-1:0] lifo_rdata,
  output logic                  lifo_wr_req,
  output logic                  lifo_rd_req,
  output logic                  lifo_enable,
  input  logic                  lifo_full,
  input  logic                  lifo_empty,
  output logic [CNT_WIDTH-1:0]  depth,
  output logic                  ovf_flag,
  output logic                  udf_flag,
`ifdef CALL_STACK_WATERMARK_EN
  output logic [CNT_WIDTH-1:0]  max_depth,
`endif
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PUSH,
    S_POP,
    S_SWAP,
    S_RESP,
    S_FLUSH
  } state_e;

  typedef enum logic [1:0] {
    REQ_NOP  = 2'b00,
    REQ_CALL = 2'b01,
    REQ_RET  = 2'b10,
    REQ_TAIL = 2'b11
  } req_e;

  // Usable LIFO capacity; the occupancy counter saturates here.
  localparam logic [CNT_WIDTH-1:0] DEPTH_MAX = CNT_WIDTH'(LIFO_DEPTH - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0] resp_pc_q, resp_pc_d;
  logic                  resp_err_q, resp_err_d;
  logic [CNT_WIDTH-1:0]  depth_q, depth_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  flush_pend_q, flush_pend_d;
`ifdef CALL_STACK_WATERMARK_EN
  logic [CNT_WIDTH-1:0]  max_q, max_d;
`endif

  logic [CNT_WIDTH-1:0]  depth_inc;
  logic [CNT_WIDTH-1:0]  depth_dec;

  assign depth_inc = (depth_q != DEPTH_MAX) ? depth_q + 1'b1 : depth_q;
  assign depth_dec = (depth_q != '0)        ? depth_q - 1'b1 : depth_q;

  // Next-state, datapath and LIFO strobe decode.
  always_comb begin
    state_d      = state_q;
    wdata_d      = wdata_q;
    resp_pc_d    = resp_pc_q;
    resp_err_d   = resp_err_q;
    depth_d      = depth_q;
    ovf_d        = ovf_q;
    udf_d        = udf_q;
    flush_pend_d = flush_pend_q;
    lifo_wr_req  = 1'b0;
    lifo_rd_req  = 1'b0;

    // A flush arriving while busy is remembered and serviced from IDLE
    // ahead of any new request.
    if (state_q != S_IDLE && flush) begin
      flush_pend_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (flush || flush_pend_q) begin
          state_d      = S_FLUSH;
          flush_pend_d = 1'b0;
        end else if (req_valid) begin
          wdata_d = req_pc;
          case (req_e'(req_type))
            REQ_CALL: state_d = S_PUSH;
            REQ_RET:  state_d = S_POP;
            REQ_TAIL: state_d = S_SWAP;
            default:  state_d = S_IDLE;
          endcase
        end
      end

      S_PUSH: begin
        if (!lifo_full) begin
          lifo_wr_req = 1'b1;
          depth_d     = depth_inc;
        end else begin
          ovf_d = 1'b1;
        end
        state_d = S_IDLE;
      end

      S_POP, S_SWAP: begin
        if (!lifo_empty) begin
          resp_pc_d   = lifo_rdata;
          resp_err_d  = 1'b0;
          lifo_rd_req = 1'b1;
          // Simultaneous read+write makes the LIFO replace its top entry,
          // so a tail call leaves the occupancy unchanged.
          if (state_q == S_SWAP) begin
            lifo_wr_req = 1'b1;
          end else begin
            depth_d = depth_dec;
          end
        end else begin
          resp_pc_d  = '0;
          resp_err_d = 1'b1;
          udf_d      = 1'b1;
        end
        state_d = S_RESP;
      end

      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
        end
      end

      S_FLUSH: begin
        if (!lifo_empty) begin
          lifo_rd_req = 1'b1;
          depth_d     = depth_dec;
        end else begin
          depth_d = '0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

`ifdef CALL_STACK_WATERMARK_EN
  // High-water mark follows depth in the same cycle it grows.
  always_comb begin
    max_d = max_q;
    if (depth_d > max_q) begin
      max_d = depth_d;
    end
  end
`endif

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wdata_q      <= '0;
      resp_pc_q    <= '0;
      resp_err_q   <= 1'b0;
      depth_q      <= '0;
      ovf_q        <= 1'b0;
      udf_q        <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wdata_q      <= wdata_d;
      resp_pc_q    <= resp_pc_d;
      resp_err_q   <= resp_err_d;
      depth_q      <= depth_d;
      ovf_q        <= ovf_d;
      udf_q        <= udf_d;
      flush_pend_q <= flush_pend_d;
    end
  end

`ifdef CALL_STACK_WATERMARK_EN
  // Watermark register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_q <= '0;
    end else begin
      max_q <= max_d;
    end
  end

  assign max_depth = max_q;
`endif

  assign req_ready   = (state_q == S_IDLE) && !flush && !flush_pend_q;
  assign resp_valid  = (state_q == S_RESP);
  assign resp_pc     = resp_pc_q;
  assign resp_err    = resp_err_q;
  assign lifo_wdata  = wdata_q;
  assign lifo_enable = 1'b1;
  assign depth       = depth_q;
  assign ovf_flag    = ovf_q;
  assign udf_flag    = udf_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_call_stack_ctrl.sv
`timescale 1ns/1ps
// Randomised bench for call_stack_ctrl: a behavioural sync_lifo sits on the
// LIFO port and an abstract queue-based stack predicts every response.
module tb_call_stack_ctrl;

  localparam int AW = 32;
  localparam int LD = 32;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_type = 2'b00;
  logic [AW-1:0] req_pc = '0;
  logic          flush = 1'b0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [AW-1:0] resp_pc;
  logic          resp_err;
  logic [AW-1:0] lifo_wdata;
  logic [AW-1:0] lifo_rdata;
  logic          lifo_wr_req;
  logic          lifo_rd_req;
  logic          lifo_enable;
  logic          lifo_full;
  logic          lifo_empty;
  logic [CW-1:0] depth;
  logic          ovf_flag;
  logic          udf_flag;
  logic          busy;
`ifdef CALL_STACK_WATERMARK_EN
  logic [CW-1:0] max_depth;
`endif

  call_stack_ctrl #(.ADDR_WIDTH(AW), .LIFO_DEPTH(LD), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type), .req_pc(req_pc),
    .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_pc(resp_pc), .resp_err(resp_err),
    .lifo_wdata(lifo_wdata), .lifo_rdata(lifo_rdata), .lifo_wr_req(lifo_wr_req),
    .lifo_rd_req(lifo_rd_req), .lifo_enable(lifo_enable), .lifo_full(lifo_full),
    .lifo_empty(lifo_empty),
    .depth(depth), .ovf_flag(ovf_flag), .udf_flag(udf_flag),
`ifdef CALL_STACK_WATERMARK_EN
    .max_depth(max_depth),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural sync_lifo: capacity LD-1, combinational top of stack.
  logic [AW-1:0] mem [LD];
  int lcnt = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;

  assign lifo_rdata = (lcnt > 0) ? mem[lcnt-1] : '0;
  assign lifo_full  = (lcnt >= LD-1);
  assign lifo_empty = (lcnt == 0);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      lcnt <= 0;
    end else begin
      if (lifo_rd_req) rd_cnt <= rd_cnt + 1;
      if (lifo_wr_req) wr_cnt <= wr_cnt + 1;
      if (lifo_rd_req && lifo_wr_req) begin
        if (lcnt > 0) mem[lcnt-1] <= lifo_wdata;
      end else if (lifo_wr_req) begin
        if (lcnt < LD) begin
          mem[lcnt] <= lifo_wdata;
          lcnt <= lcnt + 1;
        end
      end else if (lifo_rd_req) begin
        if (lcnt > 0) lcnt <= lcnt - 1;
      end
    end
  end

  // Reference model state.
  logic [AW-1:0] stk[$];
  bit m_ovf = 1'b0;
  bit m_udf = 1'b0;
  int m_max = 0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_state(input string pfx);
    chk({pfx, "_depth"}, 32'(depth), 32'(stk.size()));
    chk({pfx, "_ovf"}, 32'(ovf_flag), 32'(m_ovf));
    chk({pfx, "_udf"}, 32'(udf_flag), 32'(m_udf));
`ifdef CALL_STACK_WATERMARK_EN
    chk({pfx, "_maxdepth"}, 32'(max_depth), 32'(m_max));
`endif
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({pfx, "_lifo_en"}, 32'(lifo_enable), 32'd1);
    chk({pfx, "_busy"}, 32'(busy), 32'd0);
    chk({pfx, "_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({pfx, "_resp_pc"}, resp_pc, 32'd0);
    chk({pfx, "_resp_err"}, 32'(resp_err), 32'd0);
    chk({pfx, "_rd_req"}, 32'(lifo_rd_req), 32'd0);
    chk({pfx, "_wr_req"}, 32'(lifo_wr_req), 32'd0);
    chk({pfx, "_wdata"}, lifo_wdata, 32'd0);
    chk({pfx, "_depth"}, 32'(depth), 32'd0);
    chk({pfx, "_ovf"}, 32'(ovf_flag), 32'd0);
    chk({pfx, "_udf"}, 32'(udf_flag), 32'd0);
  endtask

  task automatic do_reset();
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    flush      = 1'b0;
    rst        = 1'b1;
    #3;
    @(negedge clk);
    rst = 1'b0;
    stk.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    m_max = 0;
  endtask

  // One request from acceptance to completion; called and returns at a negedge.
  task automatic xact(input logic [1:0] t, input logic [AW-1:0] pc,
                      input int stall, input bit fl);
    int r0, w0, k, er, ew;
    logic [AW-1:0] epc;
    logic eerr;
    bit eresp;
    epc = '0; eerr = 1'b0; er = 0; ew = 0;
    eresp = (t == 2'b10) || (t == 2'b11);
    k = 0;
    while (!req_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("req_ready", 32'(req_ready), 32'd1);
    r0 = rd_cnt;
    w0 = wr_cnt;
    req_valid = 1'b1; req_type = t; req_pc = pc;
    @(posedge clk);
    #1 req_valid = 1'b0;
    case (t)
      2'b01: if (stk.size() < LD-1) begin stk.push_back(pc); ew = 1; end else m_ovf = 1'b1;
      2'b10: if (stk.size() > 0) begin epc = stk.pop_back(); er = 1; end
             else begin eerr = 1'b1; m_udf = 1'b1; end
      2'b11: if (stk.size() > 0) begin
               epc = stk[stk.size()-1];
               stk[stk.size()-1] = pc;
               er = 1; ew = 1;
             end else begin eerr = 1'b1; m_udf = 1'b1; end
      default: ;
    endcase
    if (stk.size() > m_max) m_max = stk.size();
    if (eresp) begin
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!resp_valid && k < 20);
      chk("resp_latency", 32'(k), 32'd2);
      for (int i = 0; i < stall; i++) begin
        chk("resp_hold_valid", 32'(resp_valid), 32'd1);
        chk("resp_hold_pc", resp_pc, epc);
        if (fl && i == 0) flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
      end
      chk("resp_pc", resp_pc, epc);
      chk("resp_err", 32'(resp_err), 32'(eerr));
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
      @(negedge clk);
      chk("resp_dropped", 32'(resp_valid), 32'd0);
    end else begin
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (busy && k < 20);
      chk("back_to_idle", 32'(busy), 32'd0);
    end
    chk("rd_pulses", 32'(rd_cnt - r0), 32'(er));
    chk("wr_pulses", 32'(wr_cnt - w0), 32'(ew));
    chk_state("x");
  endtask

  // Flush: pulse=1 issues the flush from IDLE; pulse=0 waits for a pending one.
  task automatic run_flush(input bit pulse);
    int n, r0, k, bc;
    n = stk.size();
    r0 = rd_cnt;
    if (pulse) begin
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
    end
    k = 0;
    while (!busy && k < 10) begin
      @(negedge clk);
      k++;
    end
    bc = 0;
    while (busy && k < 100) begin
      bc++;
      @(negedge clk);
      k++;
    end
    stk.delete();
    chk("flush_cycles", 32'(bc), 32'(n + 1));
    chk("flush_reads", 32'(rd_cnt - r0), 32'(n));
    chk("flush_ready", 32'(req_ready), 32'd1);
    chk_state("f");
  endtask

  initial begin
    logic [1:0] t;
    int r, st;
    bit fl;

    // Reset values
    #3;
    chk_reset_outputs("rst");
    do_reset();
    chk_reset_outputs("rst_rel");

    // RET on empty stack
    xact(2'b10, 32'h55, 0, 1'b0);

    // CALL/CALL/RET
    do_reset();
    xact(2'b01, 32'h100, 0, 1'b0);
    xact(2'b01, 32'h200, 0, 1'b0);
    xact(2'b10, 32'h0, 1, 1'b0);

    // Fill to capacity, then overflow
    do_reset();
    for (int i = 1; i <= 31; i++) xact(2'b01, 32'(i), 0, 1'b0);
    xact(2'b01, 32'h20, 0, 1'b0);
    xact(2'b10, 32'h0, 0, 1'b0);

    // Tail call
    do_reset();
    xact(2'b01, 32'hA0, 0, 1'b0);
    xact(2'b11, 32'hB0, 2, 1'b0);
    xact(2'b10, 32'h0, 0, 1'b0);

    // Stalled response with flush pending, then flush of remaining entries
    do_reset();
    for (int i = 0; i < 5; i++) xact(2'b01, 32'h300 + 32'(i), 0, 1'b0);
    xact(2'b10, 32'h0, 4, 1'b1);
    run_flush(1'b0);

    // Reset in the middle of a flush
    do_reset();
    for (int i = 0; i < 3; i++) xact(2'b01, 32'h400 + 32'(i), 0, 1'b0);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("midflush_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk_reset_outputs("midflush_rst");
    do_reset();

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 5) begin
        run_flush(1'b1);
      end else begin
        t  = (r < 50) ? 2'b01 : (r < 75) ? 2'b10 : (r < 93) ? 2'b11 : 2'b00;
        st = $urandom_range(0, 3);
        fl = t[1] && (st > 0) && ($urandom_range(0, 9) == 0);
        xact(t, $urandom, st, fl);
        if (fl) run_flush(1'b0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/call_stack_ctrl.md
Name: call_stack_ctrl

Overview:
- Return-address stack controller that sits directly upstream of the sync_lifo used as the hardware call stack.
- Accepts CALL / RET / TAIL requests from the decode stage over a valid/ready handshake and sequences push, pop and replace on the LIFO port.
- Returns popped return addresses to the fetch stage over a second valid/ready handshake.
- Tracks occupancy and flags overflow and underflow. Supports a multi-cycle flush on pipeline exception.

Parameters:
- ADDR_WIDTH, 32, width of return address (matches LIFO DATA_WIDTH).
- LIFO_DEPTH, 32, depth of attached LIFO; usable capacity is LIFO_DEPTH-1 entries.
- CNT_WIDTH, $clog2(LIFO_DEPTH), width of occupancy counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  1  request valid.
- req_ready  out  1  controller can accept a request.
- req_type  in  2  01=CALL, 10=RET, 11=TAIL (RET then CALL), 00=reserved (accepted, no-op).
- req_pc  in  ADDR_WIDTH  return address to push (CALL/TAIL).
- flush  in  1  pop-all request; one-cycle pulse is sufficient.
- resp_valid  out  1  return address valid.
- resp_ready  in  1  consumer accepts response.
- resp_pc  out  ADDR_WIDTH  popped return address.
- resp_err  out  1  response produced from empty stack (underflow).
- lifo_wdata  out  ADDR_WIDTH  to LIFO data_i.
- lifo_rdata  in  ADDR_WIDTH  from LIFO data_o (combinational top of stack).
- lifo_wr_req  out  1  to LIFO wr_req.
- lifo_rd_req  out  1  to LIFO rd_req.
- lifo_enable  out  1  to LIFO enable; constant 1.
- lifo_full  in  1  from LIFO full.
- lifo_empty  in  1  from LIFO empty.
- depth  out  CNT_WIDTH  current entry count.
- ovf_flag  out  1  sticky: CALL dropped because full.
- udf_flag  out  1  sticky: RET/TAIL on empty stack.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0 except req_ready=1 and lifo_enable=1; depth=0; flags=0; resp_pc=0.
- States: IDLE, PUSH, POP, SWAP, RESP, FLUSH.
- req_ready=1 only in IDLE with flush=0. A request is accepted on a clock edge with req_valid & req_ready. req_pc is latched into lifo_wdata at acceptance.
- IDLE -> PUSH on CALL; IDLE -> POP on RET; IDLE -> SWAP on TAIL; type 00 stays in IDLE.
- flush=1 in IDLE -> FLUSH. flush takes priority over a concurrent request, which is not accepted.
- PUSH, one cycle:
  - !lifo_full: lifo_wr_req=1, depth+1.
  - lifo_full: no write, ovf_flag set.
  - Next state IDLE.
- POP, one cycle:
  - !lifo_empty: resp_pc<=lifo_rdata, resp_err<=0, lifo_rd_req=1, depth-1.
  - lifo_empty: resp_pc<=0, resp_err<=1, udf_flag set, no rd_req.
  - Next state RESP.
- SWAP, one cycle:
  - !lifo_empty: resp_pc<=lifo_rdata, lifo_rd_req=1 and lifo_wr_req=1 together (LIFO replaces top), depth unchanged.
  - lifo_empty: same response as empty POP; no push.
  - Next state RESP.
- RESP: resp_valid=1, and resp_pc/resp_err are held stable until resp_valid & resp_ready, then IDLE. resp_valid must not drop without a handshake.
- FLUSH:
  - lifo_rd_req=1 and depth-1 each cycle while !lifo_empty.
  - When lifo_empty: depth forced to 0, return to IDLE.
  - Latency = depth at entry + 1 cycles.
- flush asserted in any state other than IDLE is latched as pending. It is serviced on the next return to IDLE, before any new request.
- lifo_rd_req and lifo_wr_req are combinational from state and are never asserted outside PUSH, POP, SWAP or FLUSH.
- depth never wraps. The increment is blocked at LIFO_DEPTH-1 and the decrement at 0.
- Sticky flags clear only on rst.

Optional Feature:
- Macro CALL_STACK_WATERMARK_EN.
- Defined: extra output max_depth [CNT_WIDTH-1:0], a register holding the highest depth since reset. It updates in the same cycle depth increases and is reset to 0.
- Undefined: port and register absent; remaining behaviour identical.

Test Plan:
- CALL pc=0x100, then CALL 0x200, then RET -> resp_pc=0x200, resp_err=0, depth goes 1,2,1; RESP entered 2 cycles after RET acceptance.
- RET on empty stack after reset -> resp_pc=0, resp_err=1, udf_flag=1, lifo_rd_req never asserted.
- 31 CALLs (0x1..0x1F), then CALL 0x20 -> depth=31, 32nd CALL gives no lifo_wr_req and ovf_flag=1; subsequent RET returns 0x1F.
- CALL 0xA0, then TAIL pc=0xB0 -> resp_pc=0xA0, depth stays 1; following RET returns 0xB0.
- Push 5 entries, hold resp_ready=0 for 4 cycles during a RET response, pulse flush meanwhile -> resp_pc stable while stalled. After handshake, FLUSH asserts lifo_rd_req 4 cycles, depth=0, then req_ready=1.
- Assert rst mid-FLUSH with depth=3 -> all outputs immediately return to reset values, state IDLE, depth=0.
